// File: rtl/retire_trace_fifo.sv
// Retirement-event capture buffer: classifies each retired instruction, numbers it,
// queues it in a FIFO drained over valid/ready, and reports done once a HALT has drained.
module retire_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ret_valid,
  input  logic [15:0] ret_pc,
  input  logic [15:0] ret_inst,
  input  logic        reg_write,
  input  logic [2:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_inum,
  output logic [2:0]  out_kind,
  output logic [15:0] out_pc,
  output logic [15:0] out_inst,
  output logic [2:0]  out_reg,
  output logic [15:0] out_rdata,
  output logic [15:0] out_addr,
  output logic [15:0] out_mdata,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic [15:0] inst_count,
  output logic        done
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] K_OTHER = 3'd0;
  localparam logic [2:0] K_REG   = 3'd1;
  localparam logic [2:0] K_LD    = 3'd2;
  localparam logic [2:0] K_ST    = 3'd3;
  localparam logic [2:0] K_STU   = 3'd4;
  localparam logic [2:0] K_HALT  = 3'd5;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0] inum;
    logic [2:0]  kind;
    logic [15:0] pc;
    logic [15:0] inst;
    logic [2:0]  rd;
    logic [15:0] rdata;
    logic [15:0] addr;
    logic [15:0] mdata;
  } rec_t;

  rec_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [15:0]   inst_q, inst_d;

  logic [2:0] kind;
  logic       keep_reg, keep_addr, keep_mdata;
  logic       empty, full, accept, pop, push, drop;
  rec_t       new_rec, head;

  always_comb begin
    kind = K_OTHER;
    if (reg_write && mem_write)     kind = K_STU;
    else if (reg_write && mem_read) kind = K_LD;
    else if (reg_write)             kind = K_REG;
    else if (halt)                  kind = K_HALT;
    else if (mem_write)             kind = K_ST;
  end

  assign keep_reg   = (kind == K_REG) || (kind == K_LD) || (kind == K_STU);
  assign keep_addr  = (kind == K_LD)  || (kind == K_ST) || (kind == K_STU);
  assign keep_mdata = (kind == K_ST)  || (kind == K_STU);

  always_comb begin
    new_rec       = '0;
    new_rec.inum  = inst_q;
    new_rec.kind  = kind;
    new_rec.pc    = ret_pc;
    new_rec.inst  = ret_inst;
    new_rec.rd    = keep_reg   ? write_reg  : 3'd0;
    new_rec.rdata = keep_reg   ? write_data : 16'd0;
    new_rec.addr  = keep_addr  ? mem_addr   : 16'd0;
    new_rec.mdata = keep_mdata ? mem_data   : 16'd0;
  end

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign accept = ret_valid && (state_q == ST_RUN);
  assign pop    = !empty && out_ready;
  // A full FIFO still takes a new record when the head leaves in the same cycle.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (accept) inst_d = inst_q + 16'd1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
    case (state_q)
      ST_RUN:   if (accept && kind == K_HALT) state_d = ST_DRAIN;
      ST_DRAIN: if (empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_RUN;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
      inst_q     <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
    end
  end

  // Storage carries no reset; emptiness gating below hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  assign head      = empty ? '0 : mem_q[rd_ptr_q];
  assign out_valid = !empty;
  assign out_inum  = head.inum;
  assign out_kind  = head.kind;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_reg   = head.rd;
  assign out_rdata = head.rdata;
  assign out_addr  = head.addr;
  assign out_mdata = head.mdata;

  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign inst_count = inst_q;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Bench for retire_trace_fifo: table vectors plus directed corner sequences, checked
// against a queue-based reference of the capture buffer.
module tb_retire_trace_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ret_valid = 1'b0;
  logic [15:0] ret_pc = '0, ret_inst = '0, write_data = '0, mem_addr = '0, mem_data = '0;
  logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, halt = 1'b0;
  logic [2:0]  write_reg = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, overflow, done;
  logic [15:0] out_inum, out_pc, out_inst, out_rdata, out_addr, out_mdata, inst_count;
  logic [2:0]  out_kind, out_reg;
  logic [7:0]  drop_count;

  retire_trace_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .halt(halt), .out_valid(out_valid), .out_ready(out_ready), .out_inum(out_inum),
    .out_kind(out_kind), .out_pc(out_pc), .out_inst(out_inst), .out_reg(out_reg),
    .out_rdata(out_rdata), .out_addr(out_addr), .out_mdata(out_mdata),
    .overflow(overflow), .drop_count(drop_count), .inst_count(inst_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] inum;
    logic [2:0]  kind;
    logic [15:0] pc, inst;
    logic [2:0]  rd;
    logic [15:0] rdata, addr, mdata;
  } rec_t;

  typedef struct {
    logic        rw, mr, mw, h;
    logic [2:0]  wr;
    logic [15:0] wd, ma, md, pc, inst;
    logic [2:0]  exp_kind;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  rec_t exp_q[$];
  int   m_state = 0;        // 0 run, 1 drain, 2 done
  int   m_inst = 0, m_drop = 0;
  logic m_ovf = 1'b0;
  logic [2:0] cur_kind = 3'd0;
  int   n_popped = 0;
  logic [2:0] last_kind = 3'd0;
  logic [15:0] last_inum = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ret_valid = 0; reg_write = 0; mem_read = 0; mem_write = 0; halt = 0;
    write_reg = 0; write_data = 0; mem_addr = 0; mem_data = 0; ret_pc = 0; ret_inst = 0;
  endtask

  task automatic drive(input vec_t v);
    ret_valid = 1; reg_write = v.rw; mem_read = v.mr; mem_write = v.mw; halt = v.h;
    write_reg = v.wr; write_data = v.wd; mem_addr = v.ma; mem_data = v.md;
    ret_pc = v.pc; ret_inst = v.inst; cur_kind = v.exp_kind;
  endtask

  task automatic do_reset();
    idle(); out_ready = 0; rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    exp_q.delete(); m_state = 0; m_inst = 0; m_drop = 0; m_ovf = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_inst_count", inst_count, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  // One clock: compare head against the scoreboard, update the reference, then check status.
  task automatic tick();
    rec_t r, e;
    logic pop, acc;
    int nxt;
    pop = (exp_q.size() > 0) && out_ready;
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() == 0) begin
      chk("empty_kind", out_kind, 0);
      chk("empty_inum", out_inum, 0);
      chk("empty_pc", out_pc, 0);
    end
    if (pop) begin
      e = exp_q.pop_front();
      chk("pop_inum", out_inum, e.inum);
      chk("pop_kind", out_kind, e.kind);
      chk("pop_pc", out_pc, e.pc);
      chk("pop_inst", out_inst, e.inst);
      chk("pop_reg", out_reg, e.rd);
      chk("pop_rdata", out_rdata, e.rdata);
      chk("pop_addr", out_addr, e.addr);
      chk("pop_mdata", out_mdata, e.mdata);
      n_popped++; last_kind = e.kind; last_inum = e.inum;
      $display("pop inum=%0d kind=%0d pc=0x%04h", out_inum, out_kind, out_pc);
    end
    nxt = m_state;
    if (m_state == 1 && !pop && exp_q.size() == 0) nxt = 2;
    if (m_state == 1 && pop && (exp_q.size() + 1) == 0) nxt = 2;
    acc = ret_valid && (m_state == 0);
    if (acc) begin
      r.inum = m_inst[15:0]; r.kind = cur_kind; r.pc = ret_pc; r.inst = ret_inst;
      r.rd    = (cur_kind inside {3'd1, 3'd2, 3'd4}) ? write_reg : 3'd0;
      r.rdata = (cur_kind inside {3'd1, 3'd2, 3'd4}) ? write_data : 16'd0;
      r.addr  = (cur_kind inside {3'd2, 3'd3, 3'd4}) ? mem_addr : 16'd0;
      r.mdata = (cur_kind inside {3'd3, 3'd4}) ? mem_data : 16'd0;
      if (exp_q.size() < DEPTH) exp_q.push_back(r);
      else begin m_ovf = 1; if (m_drop < 255) m_drop++; end
      m_inst = (m_inst + 1) % 65536;
      if (cur_kind == 3'd5) nxt = 1;
    end
    m_state = nxt;
    @(posedge clk); #1;
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drop);
    chk("inst_count", inst_count, m_inst);
    chk("done", done, m_state == 2);
  endtask

  task automatic drain(input int budget);
    idle(); out_ready = 1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    chk("drain_empty", out_valid, 0);
  endtask

  vec_t tv[5];
  vec_t v;

  initial begin
    // OTHER, LD, ST, STU, REG
    tv[0] = '{0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'hC000, 3'd0};
    tv[1] = '{1, 1, 0, 0, 3'd2, 16'h5555, 16'h0040, 16'h0000, 16'h0006, 16'h8840, 3'd2};
    tv[2] = '{0, 0, 1, 0, 3'd1, 16'h1111, 16'h0042, 16'hBEEF, 16'h0008, 16'h9042, 3'd3};
    tv[3] = '{1, 0, 1, 0, 3'd5, 16'h7777, 16'h0044, 16'hCAFE, 16'h000A, 16'hA044, 3'd4};
    tv[4] = '{1, 0, 0, 1, 3'd6, 16'h2468, 16'h0099, 16'h0099, 16'h000C, 16'h1234, 3'd1};

    // Single REG capture, one-cycle latency
    do_reset();
    v = '{1, 0, 0, 0, 3'd3, 16'h1234, 16'h00AA, 16'h00BB, 16'h0002, 16'h5678, 3'd1};
    drive(v); tick(); idle();
    chk("t1_valid", out_valid, 1);
    chk("t1_kind", out_kind, 1);
    chk("t1_inum", out_inum, 0);
    chk("t1_reg", out_reg, 3);
    chk("t1_rdata", out_rdata, 16'h1234);
    chk("t1_addr", out_addr, 0);
    drain(4);

    // Table vectors back to back with consumer ready
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin drive(tv[i]); tick(); end
    drain(10);
    chk("t2_inst_count", inst_count, 5);
    chk("t2_pops", n_popped, 6);

    // Overflow: 18 retires into a 16-deep FIFO
    do_reset();
    v = '{1, 0, 0, 0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h1000, 3'd1};
    for (int i = 0; i < 18; i++) begin v.wd = 16'(i); v.pc = 16'(16'h0100 + i); drive(v); tick(); end
    chk("t3_overflow", overflow, 1);
    chk("t3_drops", drop_count, 2);
    chk("t3_inst", inst_count, 18);
    n_popped = 0;
    drain(30);
    chk("t3_pops", n_popped, 16);
    chk("t3_last_inum", last_inum, 15);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) begin v.wd = 16'(i); drive(v); tick(); end
    v.wd = 16'hF00D; out_ready = 1; drive(v); tick();
    chk("t4_overflow", overflow, 0);
    n_popped = 0;
    drain(30);
    chk("t4_pops", n_popped, 16);
    chk("t4_tail_inum", last_inum, 16);

    // HALT with 3 queued, retires continue, consumer toggles
    do_reset();
    for (int i = 0; i < 3; i++) begin v.wd = 16'(i); drive(v); tick(); end
    v = '{0, 0, 0, 1, 3'd2, 16'h9999, 16'h0000, 16'h0000, 16'h0010, 16'hF000, 3'd5};
    drive(v); tick();
    v = '{1, 0, 0, 0, 3'd1, 16'h3333, 16'h0000, 16'h0000, 16'h0020, 16'h1000, 3'd1};
    n_popped = 0;
    for (int i = 0; i < 14; i++) begin out_ready = i[0]; drive(v); tick(); end
    idle();
    chk("t5_pops", n_popped, 4);
    chk("t5_last_kind", last_kind, 5);
    chk("t5_done", done, 1);
    chk("t5_inst", inst_count, 4);

    // Asynchronous reset between edges while draining
    do_reset();
    v = '{1, 0, 0, 0, 3'd1, 16'h0001, 16'h0000, 16'h0000, 16'h0030, 16'h1000, 3'd1};
    for (int i = 0; i < 2; i++) begin drive(v); tick(); end
    v = '{0, 0, 0, 1, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0032, 16'hF000, 3'd5};
    drive(v); tick(); idle(); tick();
    chk("t6_pre_valid", out_valid, 1);
    #3 rst = 0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_done", done, 0);
    chk("t6_async_inst", inst_count, 0);
    exp_q.delete(); m_state = 0; m_inst = 0; m_drop = 0; m_ovf = 0;
    #2 rst = 1;
    @(posedge clk); #1;
    v = '{1, 0, 0, 0, 3'd4, 16'hABCD, 16'h0000, 16'h0000, 16'h0040, 16'h1000, 3'd1};
    drive(v); tick(); idle();
    chk("t6_first_inum", out_inum, 0);
    chk("t6_first_valid", out_valid, 1);
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Synthesizable retirement-event capture buffer. Sits directly downstream of the processor's commit point and consumes the same per-instruction retire signals the simulation bench monitors (PC, instruction, register write, memory access, halt).
- Classifies each retired instruction, tags it with a sequential instruction number, and queues it in a FIFO. The FIFO drains over a valid/ready port to a trace UART or debug port.
- After halt it drains and then asserts done.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ret_valid  in  1  an instruction retires this cycle.
- ret_pc  in  16  PC of the retiring instruction.
- ret_inst  in  16  instruction word.
- reg_write  in  1  register file written.
- write_reg  in  3  destination register.
- write_data  in  16  register write data.
- mem_read  in  1  memory read.
- mem_write  in  1  memory write, already qualified by memory enable.
- mem_addr  in  16  memory address.
- mem_data  in  16  memory write data.
- halt  in  1  retiring instruction is HALT.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head record.
- out_inum  out  16  instruction number.
- out_kind  out  3  record class.
- out_pc  out  16  PC.
- out_inst  out  16  instruction word.
- out_reg  out  3  destination register.
- out_rdata  out  16  register value.
- out_addr  out  16  memory address.
- out_mdata  out  16  memory data.
- overflow  out  1  sticky flag: a record was dropped.
- drop_count  out  8  number of dropped records; saturates at 255.
- inst_count  out  16  records accepted, including dropped ones; wraps.
- done  out  1  halt record drained and FIFO empty.

Behaviour:
- Reset (rst=0, async): all pointers, counters, overflow, drop_count, inst_count and done clear to 0. out_valid=0, state=RUN. All out_* data fields read 0 while empty.
- kind classification, using this priority:
  - reg_write & mem_write -> 4 STU.
  - reg_write & mem_read -> 2 LD.
  - reg_write -> 1 REG.
  - else halt -> 5 HALT.
  - else mem_write -> 3 ST.
  - else 0 OTHER (branch/NOP).
- Fields not meaningful for a kind are stored as 0: reg/rdata only for 1, 2, 4; addr only for 2, 3, 4; mdata only for 3, 4.
- Capture: in RUN, ret_valid=1 accepts a record at the clock edge.
  - out_inum = inst_count value before increment; inst_count then increments by 1.
  - Capture-to-out_valid latency is 1 cycle. There is no combinational bypass.
- Pop: out_valid & out_ready at the edge advances the head. Outputs come directly from the head entry (registered storage, combinational read of head).
- Full: count==DEPTH.
  - Push with no pop while full: record dropped, overflow set (sticky until reset), drop_count +1 (saturating), inst_count still increments.
  - Push and pop in the same cycle while full: both succeed, no drop.
- Empty: out_valid=0, and out_ready is ignored.
- Occupancy counter is AW+1 bits. Pointers wrap modulo DEPTH.
- State machine:
  - RUN: a HALT-kind record that is accepted (or dropped) -> DRAIN.
  - DRAIN: ret_valid ignored, inst_count frozen. When FIFO empty -> DONE.
  - DONE: done=1 and held. Only reset leaves DONE.
- Halt with reg_write=1 is classified by reg_write and does not trigger DRAIN; this matches commit-trace semantics.
- Reset mid-drain: all state is lost immediately, and the FIFO contents are discarded.

Test Plan:
- Reset, then ret_valid with reg_write=1, write_reg=3, write_data=0x1234, ret_pc=0x0002 -> next cycle out_valid=1, out_kind=1, out_inum=0, out_reg=3, out_rdata=0x1234, out_addr=0.
- Five back-to-back retires (OTHER, LD addr 0x0040, ST addr 0x0042 data 0xBEEF, STU, REG) with out_ready=1 -> five records in order, kinds 0, 2, 3, 4, 1; inums 0-4; inst_count=5.
- out_ready=0, 18 retires with DEPTH=16 -> 16 stored (inums 0-15), overflow=1, drop_count=2, inst_count=18; drain yields inums 0-15 only.
- Full FIFO, simultaneous retire and out_ready=1 -> no drop, overflow stays 0, the new record appears at the tail.
- Retire halt=1 (reg_write=0) at PC 0x0010 with 3 records queued, out_ready toggling, retires continuing -> later retires ignored, 4 records drained with the last kind=5, done=1 the cycle after the FIFO empties.
- Assert rst=0 asynchronously mid-DRAIN between clock edges -> out_valid, done and inst_count drop to 0 immediately; after release, the first capture has inum=0.
